// File: rtl/alu_control_pipe.sv
// alu_control_pipe
//   Registered, handshaked ALU control decoder. It sits between the decode
//   stage and the ALU in the multicycle datapath. It maps the function field
//   plus the main-decoder ALU op to an ALU control code. It holds the result
//   in a one-entry output register. MUL-class requests spend MUL_CYCLES busy
//   cycles before their control code is presented.
//
//   Optional feature macro: ALU_CTRL_PERF_CNT_EN
//     When defined, adds op_count / illegal_count performance counters.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds valid and payload stable
// until that edge, and ready may depend combinationally on the consumer's
// ready. Input side: in_valid/in_ready. Output side: out_valid/out_ready.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid          request valid
//   in_ready          block can accept a request this cycle
//   funct             function field (only low 6 bits decoded)
//   aluop             ALU op from the main decoder
//   out_valid         ctrl/multi/illegal are valid
//   out_ready         ALU consumes ctrl
//   ctrl              ALU control code
//   multi             current ctrl is a multi-cycle op
//   illegal           current ctrl came from an undefined funct
//   busy              multi-cycle countdown active
//   op_count          (perf) accepted requests, wraps
//   illegal_count     (perf) accepted illegal requests, wraps
//   state_dbg         FSM state (0 IDLE, 1 WAIT, 2 OUT) for observation
module alu_control_pipe #(
  parameter int              FUNCT_W    = 6,
  parameter int              OP_W       = 3,
  parameter int              CTRL_W     = 3,
  parameter logic [OP_W-1:0] RTYPE_OP   = 3'b111,
  parameter int              MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [OP_W-1:0]    aluop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               multi,
  output logic               illegal,
  output logic               busy,
`ifdef ALU_CTRL_PERF_CNT_EN
  output logic [15:0]        op_count,
  output logic [15:0]        illegal_count,
`endif
  output logic [1:0]         state_dbg
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              accept;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_multi;
  logic              dec_illegal;
  logic [2:0]        code;
  logic              funct_hi_zero;

  assign state_dbg = state_q;
  assign accept    = in_valid & in_ready;

  // Upper funct bits beyond the decoded six must be zero for a legal R-type.
  assign funct_hi_zero = ((funct >> 6) == '0);

  // Combinational decode of the incoming request.
  always_comb begin
    code        = 3'b000;
    dec_multi   = 1'b0;
    dec_illegal = 1'b0;
    dec_ctrl    = '0;
    if (aluop == RTYPE_OP) begin
      if (!funct_hi_zero) begin
        dec_illegal = 1'b1;
      end else begin
        case (funct[5:0])
          6'b000010: code = 3'b101;
          6'b000011: code = 3'b110;
          6'b000100: code = 3'b000;
          6'b000101: code = 3'b001;
          6'b000111: code = 3'b100;
          6'b011000: begin
            code      = 3'b111;
            dec_multi = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      dec_ctrl = CTRL_W'(code);
    end else begin
      dec_ctrl = CTRL_W'(aluop);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. An accept in OUT (with out_ready) reloads directly so
  // single-cycle ops stream back-to-back without a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = dec_multi ? S_WAIT : S_OUT;
          cnt_d   = dec_multi ? CNT_W'(MUL_CYCLES - 1) : '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (accept) begin
            state_d = dec_multi ? S_WAIT : S_OUT;
            cnt_d   = dec_multi ? CNT_W'(MUL_CYCLES - 1) : '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs derived from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_WAIT: busy = 1'b1;
      S_OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Payload register: captured at accept, held through WAIT and OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl    <= '0;
      multi   <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      ctrl    <= dec_ctrl;
      multi   <= dec_multi;
      illegal <= dec_illegal;
    end
  end

`ifdef ALU_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count      <= '0;
      illegal_count <= '0;
    end else if (accept) begin
      op_count <= op_count + 16'd1;
      if (dec_illegal) begin
        illegal_count <= illegal_count + 16'd1;
      end
    end
  end
`endif

endmodule
